usb_cmd_decoder: RTL and testbench
==================================

# usb_cmd_decoder

Upstream command stage for the USB MMIO path. It parses 4-byte command frames from the bulk-OUT byte stream into the decoded-command bundle consumed by the APB bridge. It holds the command until the bridge returns a ready pulse with a 16-bit value, or until a timeout expires. When the host requests a reply, it serialises a 4-byte response frame onto the bulk-IN byte stream.

## Interface
- TIMEOUT_BITS, 10, width of the wait counter; timeout fires after 2^TIMEOUT_BITS-1 cycles without `cmd_rdy_i`.

Ports, clock and reset first:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- s_tvalid  in  1  OUT-stream byte valid
- s_tready  out  1  OUT-stream byte accept
- s_tlast  in  1  last byte of OUT frame
- s_tdata  in  8  OUT-stream byte
- cmd_vld_o  out  1  decoded command valid, held until completion or timeout
- cmd_ack_o  out  1  host requested acknowledgement
- cmd_dir_o  out  1  1 = read, 0 = write
- cmd_cmd_o  out  2  command code
- cmd_tag_o  out  4  transaction tag
- cmd_val_o  out  16  command value (address/data)
- cmd_lun_o  out  4  logical unit
- cmd_rdy_i  in  1  single-cycle completion pulse from bridge
- cmd_val_i  in  16  completion value, valid with `cmd_rdy_i`
- m_tvalid  out  1  IN-stream byte valid
- m_tready  in  1  IN-stream byte accept
- m_tlast  out  1  last byte of response
- m_tdata  out  8  IN-stream byte
- err_count_o  out  8  saturating count of discarded frames

## Operation
OUT frame layout:
- byte0: [7:6] cmd, [5] dir, [4] ack, [3:0] lun
- byte1: [3:0] tag, [7:4] reserved (ignored)
- byte2: val[7:0]
- byte3: val[15:8], with `s_tlast` set

States:
- RECV: `s_tready`=1; a 2-bit byte counter advances on each accepted byte, and fields are captured per byte.
  - Accepted byte with `s_tlast`=1 at count 0..2: frame discarded, `err_count_o`+1, counter cleared, stay in RECV.
  - byte3 with `s_tlast`=1: go to ISSUE.
  - byte3 with `s_tlast`=0: go to DROP, `err_count_o`+1.
- DROP: `s_tready`=1; discard bytes up to and including the `s_tlast` byte, then go to RECV.
- ISSUE: `cmd_vld_o`=1 with all fields stable, `s_tready`=0. The wait counter clears on entry and increments each cycle.
  - `cmd_rdy_i`=1: capture `cmd_val_i`, status=0x0.
  - Counter reaches 2^TIMEOUT_BITS-1 without `cmd_rdy_i`: status=0x1, value=0x0000.
  - If `cmd_rdy_i` coincides with the timeout, `cmd_rdy_i` wins (status 0x0).
  - On exit, go to RESP if dir=1, ack=1, or a timeout occurred; otherwise go to RECV.
- RESP: send 4 bytes, advancing on `m_tvalid`&&`m_tready`, then go to RECV.
  - byte0: {status[3:0], tag}
  - byte1: {4'h0, lun}
  - byte2: val[7:0]
  - byte3: val[15:8], with `m_tlast`=1

Other rules:
- `cmd_rdy_i` outside ISSUE is ignored.
- `err_count_o` saturates at 0xFF.
- Reset mid-frame, mid-ISSUE or mid-RESP abandons all state and returns to RECV with the counter cleared. A partially sent response is not completed.

## Timing
- Reset values: `s_tready`=0, `cmd_vld_o`=0, all `cmd_*_o`=0, `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0x00, `err_count_o`=0x00. `s_tready` rises the cycle after reset deasserts.
- byte3 accepted in cycle N: `cmd_vld_o`=1 in N+1, and `s_tready`=0 from N+1.
- `cmd_rdy_i` in cycle M: `cmd_vld_o`=0 in M+1. Then either `m_tvalid`=1 with byte0 in M+1, or `s_tready`=1 in M+1 when no response is sent.
- Timeout: `cmd_vld_o` high for exactly 2^TIMEOUT_BITS-1 cycles, then falls.
- Response bytes hold while `m_tready`=0. After byte3 handshakes in cycle K, `m_tvalid`=0 and `s_tready`=1 in K+1.
- Back-to-back frames: the minimum gap is the ISSUE/RESP duration. There is no input buffering.
- All outputs are registered.

## Test plan
- Read command: frame 0x A3,0x05,0x34,0x12 (cmd=2, dir=1, lun=3, tag=5, val=0x1234); `cmd_rdy_i` with 0xBEEF three cycles later -> `cmd_vld_o` held exactly 3 cycles; response 0x05,0x03,0xEF,0xBE with `m_tlast` on byte3.
- Write without ack: frame 0x41,0x02,0xCD,0xAB -> `cmd_dir_o`=0, `cmd_val_o`=0xABCD; `cmd_rdy_i` -> no IN bytes; `s_tready`=1 the next cycle.
- Timeout (TIMEOUT_BITS=4): read frame with no `cmd_rdy_i` -> `cmd_vld_o` high 15 cycles; response 0x1t,0x0l,0x00,0x00, where t = tag and l = lun.
- Malformed frames:
  - `s_tlast` on byte1 -> no `cmd_vld_o`, `err_count_o`=1.
  - 6-byte frame -> DROP consumes bytes 4..5, `err_count_o`=2.
  - A following valid frame then decodes correctly.
- Backpressure: `m_tready` toggling 1,0,0,1 during the response -> bytes unchanged while stalled, no byte lost or duplicated.
- Reset during ISSUE and during RESP byte1 -> all outputs at reset values next cycle; a new frame is accepted afterwards.

Source files
------------

// File: rtl/usb_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : usb_cmd_decoder
// Brief    : Parses 4-byte bulk-OUT command frames, holds the decoded command
//            for the APB bridge, and serialises the 4-byte bulk-IN response.
// Revision : 1.0
// ============================================================================
module usb_cmd_decoder #(
    parameter int TIMEOUT_BITS = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic        s_tlast,
    input  logic [7:0]  s_tdata,
    output logic        cmd_vld_o,
    output logic        cmd_ack_o,
    output logic        cmd_dir_o,
    output logic [1:0]  cmd_cmd_o,
    output logic [3:0]  cmd_tag_o,
    output logic [15:0] cmd_val_o,
    output logic [3:0]  cmd_lun_o,
    input  logic        cmd_rdy_i,
    input  logic [15:0] cmd_val_i,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic [7:0]  m_tdata,
    output logic [7:0]  err_count_o
);

    localparam logic [1:0] c_ST_RECV  = 2'd0;
    localparam logic [1:0] c_ST_DROP  = 2'd1;
    localparam logic [1:0] c_ST_ISSUE = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    // Wait counter starts at 0 on the first ISSUE cycle, so the last ISSUE
    // cycle before a timeout sees the value 2^TIMEOUT_BITS-2.
    localparam logic [TIMEOUT_BITS-1:0] c_WAIT_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

    logic [1:0]              r_state;
    logic [1:0]              r_byte_cnt;
    logic [7:0]              r_hdr;
    logic [3:0]              r_tag;
    logic [7:0]              r_val_lo;
    logic [TIMEOUT_BITS-1:0] r_wait;
    logic [15:0]             r_rsp_val;
    logic [1:0]              r_rsp_idx;

    logic        r_s_tready;
    logic        r_cmd_vld;
    logic        r_cmd_ack;
    logic        r_cmd_dir;
    logic [1:0]  r_cmd_cmd;
    logic [3:0]  r_cmd_tag;
    logic [15:0] r_cmd_val;
    logic [3:0]  r_cmd_lun;
    logic        r_m_tvalid;
    logic        r_m_tlast;
    logic [7:0]  r_m_tdata;
    logic [7:0]  r_err_count;

    logic        w_s_acc;
    logic        w_m_acc;
    logic        w_timeout;
    logic        w_need_rsp;
    logic [3:0]  w_status;
    logic [15:0] w_rsp_val;
    logic [7:0]  w_err_next;

    assign w_s_acc    = s_tvalid & r_s_tready;
    assign w_m_acc    = r_m_tvalid & m_tready;
    assign w_timeout  = (r_wait == c_WAIT_LAST);
    assign w_need_rsp = r_cmd_dir | r_cmd_ack | ~cmd_rdy_i;
    assign w_status   = cmd_rdy_i ? 4'h0 : 4'h1;
    assign w_rsp_val  = cmd_rdy_i ? cmd_val_i : 16'h0000;
    assign w_err_next = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_ST_RECV;
            r_byte_cnt  <= 2'd0;
            r_hdr       <= 8'h00;
            r_tag       <= 4'h0;
            r_val_lo    <= 8'h00;
            r_wait      <= '0;
            r_rsp_val   <= 16'h0000;
            r_rsp_idx   <= 2'd0;
            r_s_tready  <= 1'b0;
            r_cmd_vld   <= 1'b0;
            r_cmd_ack   <= 1'b0;
            r_cmd_dir   <= 1'b0;
            r_cmd_cmd   <= 2'd0;
            r_cmd_tag   <= 4'h0;
            r_cmd_val   <= 16'h0000;
            r_cmd_lun   <= 4'h0;
            r_m_tvalid  <= 1'b0;
            r_m_tlast   <= 1'b0;
            r_m_tdata   <= 8'h00;
            r_err_count <= 8'h00;
        end else begin
            case (r_state)
                c_ST_RECV: begin
                    r_s_tready <= 1'b1;
                    if (w_s_acc) begin
                        case (r_byte_cnt)
                            2'd0:    r_hdr    <= s_tdata;
                            2'd1:    r_tag    <= s_tdata[3:0];
                            2'd2:    r_val_lo <= s_tdata;
                            default: ;
                        endcase
                        if (r_byte_cnt == 2'd3) begin
                            r_byte_cnt <= 2'd0;
                            if (s_tlast) begin
                                // Outputs load together so the bridge never sees a partial command.
                                r_state    <= c_ST_ISSUE;
                                r_s_tready <= 1'b0;
                                r_cmd_vld  <= 1'b1;
                                r_wait     <= '0;
                                r_cmd_cmd  <= r_hdr[7:6];
                                r_cmd_dir  <= r_hdr[5];
                                r_cmd_ack  <= r_hdr[4];
                                r_cmd_lun  <= r_hdr[3:0];
                                r_cmd_tag  <= r_tag;
                                r_cmd_val  <= {s_tdata, r_val_lo};
                            end else begin
                                r_state     <= c_ST_DROP;
                                r_err_count <= w_err_next;
                            end
                        end else if (s_tlast) begin
                            r_byte_cnt  <= 2'd0;
                            r_err_count <= w_err_next;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end

                c_ST_DROP: begin
                    if (w_s_acc && s_tlast) begin
                        r_state <= c_ST_RECV;
                    end
                end

                c_ST_ISSUE: begin
                    r_wait <= r_wait + 1'b1;
                    if (cmd_rdy_i || w_timeout) begin
                        r_cmd_vld <= 1'b0;
                        r_rsp_val <= w_rsp_val;
                        if (w_need_rsp) begin
                            r_state    <= c_ST_RESP;
                            r_m_tvalid <= 1'b1;
                            r_m_tlast  <= 1'b0;
                            r_m_tdata  <= {w_status, r_cmd_tag};
                            r_rsp_idx  <= 2'd0;
                        end else begin
                            r_state    <= c_ST_RECV;
                            r_s_tready <= 1'b1;
                        end
                    end
                end

                c_ST_RESP: begin
                    if (w_m_acc) begin
                        r_rsp_idx <= r_rsp_idx + 2'd1;
                        case (r_rsp_idx)
                            2'd0: r_m_tdata <= {4'h0, r_cmd_lun};
                            2'd1: r_m_tdata <= r_rsp_val[7:0];
                            2'd2: begin
                                r_m_tdata <= r_rsp_val[15:8];
                                r_m_tlast <= 1'b1;
                            end
                            default: begin
                                r_m_tvalid <= 1'b0;
                                r_m_tlast  <= 1'b0;
                                r_m_tdata  <= 8'h00;
                                r_state    <= c_ST_RECV;
                                r_s_tready <= 1'b1;
                            end
                        endcase
                    end
                end

                default: r_state <= c_ST_RECV;
            endcase
        end
    end

    assign s_tready    = r_s_tready;
    assign cmd_vld_o   = r_cmd_vld;
    assign cmd_ack_o   = r_cmd_ack;
    assign cmd_dir_o   = r_cmd_dir;
    assign cmd_cmd_o   = r_cmd_cmd;
    assign cmd_tag_o   = r_cmd_tag;
    assign cmd_val_o   = r_cmd_val;
    assign cmd_lun_o   = r_cmd_lun;
    assign m_tvalid    = r_m_tvalid;
    assign m_tlast     = r_m_tlast;
    assign m_tdata     = r_m_tdata;
    assign err_count_o = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_usb_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_cmd_decoder
// Brief    : Randomised and directed bench for usb_cmd_decoder, checked every
//            cycle against a queue-based frame/response model.
// Revision : 1.0
// ============================================================================
module tb_usb_cmd_decoder;

    localparam int c_TIMEOUT_BITS = 4;
    localparam int c_TMO          = (1 << c_TIMEOUT_BITS) - 1;

    logic        clock;
    logic        reset;
    logic        s_tvalid, s_tready, s_tlast;
    logic [7:0]  s_tdata;
    logic        cmd_vld_o, cmd_ack_o, cmd_dir_o;
    logic [1:0]  cmd_cmd_o;
    logic [3:0]  cmd_tag_o, cmd_lun_o;
    logic [15:0] cmd_val_o;
    logic        cmd_rdy_i;
    logic [15:0] cmd_val_i;
    logic        m_tvalid, m_tready, m_tlast;
    logic [7:0]  m_tdata;
    logic [7:0]  err_count_o;

    usb_cmd_decoder #(.TIMEOUT_BITS(c_TIMEOUT_BITS)) dut (
        .clock(clock), .reset(reset),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tdata(s_tdata),
        .cmd_vld_o(cmd_vld_o), .cmd_ack_o(cmd_ack_o), .cmd_dir_o(cmd_dir_o),
        .cmd_cmd_o(cmd_cmd_o), .cmd_tag_o(cmd_tag_o), .cmd_val_o(cmd_val_o),
        .cmd_lun_o(cmd_lun_o), .cmd_rdy_i(cmd_rdy_i), .cmd_val_i(cmd_val_i),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tdata(m_tdata),
        .err_count_o(err_count_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    // Behavioural model: frames are collected as byte queues and responses
    // are queues of bytes still to be sent.
    logic        md_ready = 1'b0, md_drop = 1'b0, md_issue = 1'b0, md_in_reset = 1'b0;
    int          md_age = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  rsp_q[$];
    logic [7:0]  md_err = 8'h00;
    logic [1:0]  md_cmd = 2'd0;
    logic        md_dir = 1'b0, md_ack = 1'b0;
    logic [3:0]  md_tag = 4'h0, md_lun = 4'h0;
    logic [15:0] md_val = 16'h0;

    task automatic err_bump();
        if (md_err != 8'hFF) md_err++;
    endtask

    task automatic model_step();
        logic [7:0]  b0, b1;
        logic [15:0] v;
        logic [3:0]  st;
        if (reset) begin
            md_ready = 0; md_drop = 0; md_issue = 0; md_age = 0; md_err = 8'h00;
            rx_q.delete(); rsp_q.delete(); md_in_reset = 1;
            return;
        end
        md_in_reset = 0;
        if (md_issue) begin
            md_age++;
            if (cmd_rdy_i || md_age == c_TMO) begin
                st = cmd_rdy_i ? 4'h0 : 4'h1;
                v  = cmd_rdy_i ? cmd_val_i : 16'h0000;
                md_issue = 0;
                if (md_dir || md_ack || !cmd_rdy_i) begin
                    rsp_q.push_back({st, md_tag});
                    rsp_q.push_back({4'h0, md_lun});
                    rsp_q.push_back(v[7:0]);
                    rsp_q.push_back(v[15:8]);
                end else md_ready = 1;
            end
        end else if (rsp_q.size() > 0) begin
            if (m_tready) begin
                void'(rsp_q.pop_front());
                if (rsp_q.size() == 0) md_ready = 1;
            end
        end else if (md_ready && s_tvalid) begin
            if (md_drop) begin
                if (s_tlast) md_drop = 0;
            end else begin
                rx_q.push_back(s_tdata);
                if (rx_q.size() == 4) begin
                    if (s_tlast) begin
                        b0 = rx_q[0]; b1 = rx_q[1];
                        md_cmd = b0[7:6]; md_dir = b0[5]; md_ack = b0[4]; md_lun = b0[3:0];
                        md_tag = b1[3:0]; md_val = {s_tdata, rx_q[2]};
                        md_issue = 1; md_age = 0; md_ready = 0;
                    end else begin
                        err_bump(); md_drop = 1;
                    end
                    rx_q.delete();
                end else if (s_tlast) begin
                    err_bump(); rx_q.delete();
                end
            end
        end else md_ready = 1;
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    // Per-cycle comparison plus a small monitor used by the directed cases.
    int         vld_cycles = 0;
    logic [8:0] mon_q[$];
    bit         snap_taken = 0;
    logic [27:0] snap = '0;

    initial forever begin
        @(negedge clock);
        check("s_tready", 64'(s_tready), 64'(md_ready));
        check("cmd_vld", 64'(cmd_vld_o), 64'(md_issue));
        check("err_count", 64'(err_count_o), 64'(md_err));
        check("m_tvalid", 64'(m_tvalid), 64'(rsp_q.size() > 0));
        if (md_issue)
            check("cmd_fields", 64'({cmd_cmd_o, cmd_dir_o, cmd_ack_o, cmd_tag_o, cmd_lun_o, cmd_val_o}),
                  64'({md_cmd, md_dir, md_ack, md_tag, md_lun, md_val}));
        if (rsp_q.size() > 0)
            check("m_byte", 64'({m_tlast, m_tdata}), 64'({rsp_q.size() == 1, rsp_q[0]}));
        else
            check("m_tlast_idle", 64'(m_tlast), 64'(0));
        if (md_in_reset)
            check("reset_fields", 64'({cmd_cmd_o, cmd_tag_o, cmd_lun_o, cmd_val_o, m_tdata}), 64'(0));
        if (cmd_vld_o) vld_cycles++;
        if (cmd_vld_o && !snap_taken) begin
            snap = {cmd_cmd_o, cmd_dir_o, cmd_ack_o, cmd_tag_o, cmd_lun_o, cmd_val_o};
            snap_taken = 1;
        end
        if (m_tvalid && m_tready) mon_q.push_back({m_tlast, m_tdata});
    end

    // Bridge / IN-sink driver.
    int          rdy_plan = 0;
    logic [15:0] rdy_val = 16'h0;
    bit          rdy_noise = 0;
    int          tready_mode = 0;
    bit          pat[$];
    int          pat_idx = 0;
    bit          rand_gaps = 0;

    initial begin
        cmd_rdy_i = 0; cmd_val_i = 16'h0; m_tready = 1;
        forever begin
            @(posedge clock); #1;
            cmd_rdy_i = 0;
            cmd_val_i = 16'($urandom);
            if (md_issue) begin
                if (rdy_plan != 0 && md_age + 1 == rdy_plan) begin
                    cmd_rdy_i = 1; cmd_val_i = rdy_val;
                end
            end else if (rdy_noise) cmd_rdy_i = ($urandom_range(0, 7) == 0);
            case (tready_mode)
                0: m_tready = 1;
                1: m_tready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (rsp_q.size() > 0 && pat_idx < pat.size()) begin
                        m_tready = pat[pat_idx]; pat_idx++;
                    end else m_tready = 1;
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    logic [7:0] tx_q[$];

    task automatic send_byte(input logic [7:0] b, input logic last);
        bit acc = 0;
        if (rand_gaps) begin
            s_tvalid = 0;
            repeat ($urandom_range(0, 2)) tick();
        end
        s_tvalid = 1; s_tdata = b; s_tlast = last;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clock); acc = s_tready;
            @(posedge clock); #1;
        end
        s_tvalid = 0; s_tlast = 0; s_tdata = 8'($urandom);
        check("s_handshake", 64'(acc), 64'(1));
    endtask

    task automatic send_frame();
        for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], i == tx_q.size() - 1);
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int n = 0; n < 400 && !idle; n++) begin
            idle = md_ready && !md_issue && (rsp_q.size() == 0) && !md_drop && (rx_q.size() == 0);
            if (!idle) tick();
        end
        tick();
    endtask

    task automatic run_cmd(input logic [31:0] bytes, input int plan, input logic [15:0] val);
        rdy_plan = plan; rdy_val = val;
        mon_q.delete(); vld_cycles = 0; snap_taken = 0;
        tx_q = {bytes[31:24], bytes[23:16], bytes[15:8], bytes[7:0]};
        send_frame();
        wait_idle();
    endtask

    task automatic check_resp(input string name, input logic [35:0] exp);
        logic [8:0] e, g;
        check(name, 64'(mon_q.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            e = exp[35 - 9*i -: 9];
            g = (i < mon_q.size()) ? mon_q[i] : 9'h1FF;
            check(name, 64'(g), 64'(e));
        end
    endtask

    task automatic pulse_reset_and_check();
        reset = 1; tick();
        check("reset_ctrl", 64'({s_tready, cmd_vld_o, cmd_ack_o, cmd_dir_o, m_tvalid, m_tlast}), 64'(0));
        check("reset_cmd", 64'({cmd_cmd_o, cmd_tag_o, cmd_lun_o, cmd_val_o}), 64'(0));
        check("reset_m_tdata", 64'(m_tdata), 64'(0));
        check("reset_err", 64'(err_count_o), 64'(0));
        reset = 0; tick();
    endtask

    initial begin
        int kind, len;
        reset = 1; s_tvalid = 0; s_tlast = 0; s_tdata = 8'h00;
        repeat (3) tick();
        pulse_reset_and_check();
        check("s_tready_rise", 64'(s_tready), 64'(1));

        // Read command, completion after three cycles.
        run_cmd(32'hA3053412, 3, 16'hBEEF);
        check("read_fields", 64'(snap), 64'({2'd2, 1'b1, 1'b0, 4'd5, 4'd3, 16'h1234}));
        check("read_vld_cycles", 64'(vld_cycles), 64'(3));
        check_resp("read_resp", {9'h005, 9'h003, 9'h0EF, 9'h1BE});

        // Write without ack: no response bytes.
        run_cmd(32'h4102CDAB, 2, 16'h1111);
        check("write_fields", 64'(snap), 64'({2'd1, 1'b0, 1'b0, 4'd2, 4'd1, 16'hABCD}));
        check("write_vld_cycles", 64'(vld_cycles), 64'(2));
        check("write_no_resp", 64'(mon_q.size()), 64'(0));

        // Timeout, and completion on the very last ISSUE cycle.
        run_cmd(32'h29070000, 0, 16'h0);
        check("tmo_vld_cycles", 64'(vld_cycles), 64'(c_TMO));
        check_resp("tmo_resp", {9'h017, 9'h009, 9'h000, 9'h100});
        run_cmd(32'h29070000, c_TMO, 16'h1357);
        check("edge_vld_cycles", 64'(vld_cycles), 64'(c_TMO));
        check_resp("edge_resp", {9'h007, 9'h009, 9'h057, 9'h113});

        // Malformed frames, then a good write-with-ack.
        pulse_reset_and_check();
        mon_q.delete(); vld_cycles = 0;
        tx_q = {8'h11, 8'h22}; send_frame(); wait_idle();
        check("short_err", 64'(err_count_o), 64'(1));
        tx_q = {8'hA3, 8'h05, 8'h34, 8'h12, 8'h99, 8'h88}; send_frame(); wait_idle();
        check("long_err", 64'(err_count_o), 64'(2));
        check("malformed_no_vld", 64'(vld_cycles), 64'(0));
        run_cmd(32'h500A7856, 1, 16'h0F0F);
        check("ack_fields", 64'(snap), 64'({2'd1, 1'b0, 1'b1, 4'hA, 4'd0, 16'h5678}));
        check_resp("ack_resp", {9'h00A, 9'h000, 9'h00F, 9'h10F});

        // Backpressure 1,0,0,1.
        tready_mode = 2; pat = {1'b1, 1'b0, 1'b0, 1'b1}; pat_idx = 0;
        run_cmd(32'hA3053412, 1, 16'hCAFE);
        check_resp("bp_resp", {9'h005, 9'h003, 9'h0FE, 9'h1CA});
        tready_mode = 0;

        // Reset during ISSUE.
        rdy_plan = 0;
        tx_q = {8'hA3, 8'h05, 8'h34, 8'h12}; send_frame();
        repeat (3) tick();
        pulse_reset_and_check();
        run_cmd(32'h4102CDAB, 2, 16'h0);
        check("post_rst_fields", 64'(snap), 64'({2'd1, 1'b0, 1'b0, 4'd2, 4'd1, 16'hABCD}));

        // Reset while response byte1 is on the bus.
        tready_mode = 2; pat = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; pat_idx = 0;
        rdy_plan = 1; rdy_val = 16'h7777;
        tx_q = {8'hA3, 8'h05, 8'h34, 8'h12}; send_frame();
        for (int n = 0; n < 50 && rsp_q.size() != 3; n++) tick();
        check("at_byte1", 64'({m_tvalid, m_tdata}), 64'({1'b1, 8'h03}));
        pulse_reset_and_check();
        tready_mode = 0;
        run_cmd(32'hA3053412, 2, 16'h2468);
        check_resp("post_rst_resp", {9'h005, 9'h003, 9'h068, 9'h124});

        // Randomised traffic with random backpressure, noise and resets.
        rdy_noise = 1; tready_mode = 1; rand_gaps = 1;
        for (int f = 0; f < 150; f++) begin
            kind = $urandom_range(0, 9);
            len  = (kind == 0) ? $urandom_range(1, 3) : (kind == 1) ? $urandom_range(5, 7) : 4;
            tx_q.delete();
            for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom));
            rdy_plan = $urandom_range(0, c_TMO + 1);
            rdy_val  = 16'($urandom);
            send_frame();
            if ($urandom_range(0, 11) == 0) begin
                repeat ($urandom_range(0, 8)) tick();
                reset = 1; tick(); reset = 0;
            end
            wait_idle();
        end

        // Error counter saturation.
        rdy_noise = 0; tready_mode = 0; rand_gaps = 0;
        pulse_reset_and_check();
        for (int i = 0; i < 260; i++) send_byte(8'($urandom), 1'b1);
        tick();
        check("err_saturate", 64'(err_count_o), 64'(8'hFF));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
